fe: RTL and testbench
=====================

FE -- requirements
Module: fe

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h00000000, first fetch address after reset.
REQ-002 SHALL have port i_clk  input  1  global clock, all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port o_imem_raddr  output  32  instruction memory read address (combinational read, data returned same cycle).
REQ-005 SHALL have port i_imem_rdata  input  32  instruction word at o_imem_raddr.
REQ-006 SHALL have port i_hold  input  1  decode stall request (load-use); freeze PC and IF/ID.
REQ-007 SHALL have port i_jal / i_jalr  input  1 each  jump resolved in decode (already gated by decode valid).
REQ-008 SHALL have port i_immediate  input  32  decoded immediate of the instruction in decode.
REQ-009 SHALL have port i_jalr_rs1  input  32  forwarded rs1 value for jalr.
REQ-010 SHALL have port i_branch_taken  input  1 and i_branch_target  input  32  taken branch resolved in execute.
REQ-011 SHALL have port o_inst  output  32, o_pc  output  32, o_nxt_pc  output  32, o_vld  output  1  IF/ID register contents.
REQ-012 SHALL have port o_flush  output  1  squash request to decode.
REQ-013 SHALL have port o_stall_cnt  output  32 and o_flush_cnt  output  32  performance counters.

Function
REQ-014 SHALL hold a PC register pc_ff; o_imem_raddr SHALL equal pc_ff combinationally.
REQ-015 SHALL compute next PC with strict priority: branch > hold > jal/jalr > sequential.
REQ-016 Branch: i_branch_taken=1 SHALL load pc_ff<=i_branch_target and IF/ID<=bubble, regardless of i_hold, i_jal, i_jalr.
REQ-017 o_flush SHALL equal i_branch_taken combinationally (same cycle).
REQ-018 Hold: i_hold=1 with no branch SHALL keep pc_ff and all IF/ID outputs unchanged; jal/jalr SHALL be ignored that cycle (decode re-presents them).
REQ-019 Jal: i_jal=1 SHALL load pc_ff<=o_pc+i_immediate (mod 2^32) and IF/ID<=bubble.
REQ-020 Jalr: i_jalr=1 SHALL load pc_ff<=(i_jalr_rs1+i_immediate)&32'hFFFFFFFE and IF/ID<=bubble; i_jal and i_jalr both high SHALL behave as jal.
REQ-021 Sequential: pc_ff<=pc_ff+4 (wraps 32'hFFFFFFFC->0); IF/ID<=(i_imem_rdata, pc_ff, pc_ff+4, vld=1).
REQ-022 Bubble SHALL be o_inst=32'h00000033, o_vld=0, o_pc/o_nxt_pc unchanged.
REQ-023 Fetch-to-decode latency SHALL be exactly one cycle; redirect penalty SHALL be 1 bubble (jal/jalr) and 2 bubbles (branch, with decode squashing via o_flush).

Reset
REQ-024 i_rst=1 SHALL set pc_ff=RESET_ADDR, o_inst=32'h00000033, o_vld=0, o_pc=0, o_nxt_pc=0, both counters=0; o_flush follows REQ-017.
REQ-025 Reset SHALL override all redirects and hold; first o_vld=1 SHALL appear the second rising edge after i_rst deasserts, with o_pc=RESET_ADDR.
REQ-026 Reset asserted mid-hold or mid-redirect SHALL discard the pending operation completely.

Configuration
REQ-027 Macro FE_PERF_CNT_EN defined: o_stall_cnt SHALL increment on each cycle with i_hold=1 and i_branch_taken=0; o_flush_cnt SHALL increment on each cycle with i_branch_taken, i_jal or i_jalr causing a bubble; both wrap at 2^32.
REQ-028 Macro FE_PERF_CNT_EN undefined: counter logic SHALL be absent and both ports SHALL be tied to 32'd0.

Verification
REQ-029 Reset release, RESET_ADDR=0, imem returns addr-based words -> o_vld=1 at 2nd edge, o_pc=0, o_nxt_pc=4, then o_pc 4,8,12.
REQ-030 i_hold=1 for 3 cycles at o_pc=8 -> o_pc/o_inst frozen 3 cycles, o_stall_cnt=3 (macro on), fetch resumes at 12.
REQ-031 i_jal=1, o_pc=0x10, i_immediate=0x20 -> one bubble (o_vld=0, o_inst=0x33), next o_pc=0x30.
REQ-032 i_jalr=1, i_jalr_rs1=0x101, i_immediate=0x4 -> o_imem_raddr=0x104 next cycle.
REQ-033 i_branch_taken=1, target 0x200, with i_hold=1 and i_jal=1 same cycle -> o_flush=1, branch wins, o_pc=0x200 with o_vld=1 two edges later.
REQ-034 pc_ff=0xFFFFFFFC sequential -> next o_imem_raddr=0; macro off -> counters read 0 throughout.

Source files
------------

// File: rtl/fe.sv
// rtl/fe.sv - instruction fetch stage: PC register, IF/ID register, redirect and stall handling
//
// Purpose:
//   Holds the program counter, drives a combinational instruction memory read,
//   and captures the fetched word into the IF/ID register. Redirects:
//   execute-stage taken branch > decode hold > decode jal/jalr > sequential.
//
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   o_imem_raddr / i_imem_rdata     instruction memory read (data same cycle)
//   i_hold                          decode stall: freeze PC and IF/ID
//   i_jal, i_jalr, i_immediate,
//   i_jalr_rs1                      jump resolved in decode
//   i_branch_taken, i_branch_target taken branch resolved in execute
//   o_inst, o_pc, o_nxt_pc, o_vld   IF/ID register contents
//   o_flush                         squash request to decode (same cycle as branch)
//   o_stall_cnt, o_flush_cnt        performance counters
//
// Configuration:
//   FE_PERF_CNT_EN  defined: counters implemented; undefined: counters tied to 0.

module fe #(
    parameter logic [31:0] RESET_ADDR = 32'h00000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_imem_raddr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_hold,
    input  logic        i_jal,
    input  logic        i_jalr,
    input  logic [31:0] i_immediate,
    input  logic [31:0] i_jalr_rs1,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_nxt_pc,
    output logic        o_vld,
    output logic        o_flush,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt
);

    localparam logic [31:0] NOP = 32'h00000033;

    logic [31:0] pc_q,    pc_d;
    logic [31:0] inst_q,  inst_d;
    logic [31:0] idpc_q,  idpc_d;
    logic [31:0] nxt_q,   nxt_d;
    logic        vld_q,   vld_d;

    logic [31:0] pc_plus4;
    logic [31:0] jal_tgt;
    logic [31:0] jalr_tgt;
    logic        stall_ev;
    logic        bubble_ev;

    assign pc_plus4 = pc_q + 32'd4;
    // jal is relative to the instruction sitting in decode, i.e. the IF/ID pc
    assign jal_tgt  = idpc_q + i_immediate;
    assign jalr_tgt = (i_jalr_rs1 + i_immediate) & 32'hFFFFFFFE;

    // A held cycle swallows any jump; decode re-presents it after the hold
    assign stall_ev  = i_hold & ~i_branch_taken;
    assign bubble_ev = i_branch_taken | (~i_hold & (i_jal | i_jalr));

    always_comb begin
        pc_d   = pc_q;
        inst_d = inst_q;
        idpc_d = idpc_q;
        nxt_d  = nxt_q;
        vld_d  = vld_q;
        if (i_branch_taken) begin
            pc_d   = i_branch_target;
            inst_d = NOP;
            vld_d  = 1'b0;
        end else if (i_hold) begin
            pc_d = pc_q;
        end else if (i_jal) begin
            pc_d   = jal_tgt;
            inst_d = NOP;
            vld_d  = 1'b0;
        end else if (i_jalr) begin
            pc_d   = jalr_tgt;
            inst_d = NOP;
            vld_d  = 1'b0;
        end else begin
            pc_d   = pc_plus4;
            inst_d = i_imem_rdata;
            idpc_d = pc_q;
            nxt_d  = pc_plus4;
            vld_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q   <= RESET_ADDR;
            inst_q <= NOP;
            idpc_q <= 32'd0;
            nxt_q  <= 32'd0;
            vld_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            inst_q <= inst_d;
            idpc_q <= idpc_d;
            nxt_q  <= nxt_d;
            vld_q  <= vld_d;
        end
    end

`ifdef FE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_ev)  stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bubble_ev) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    logic unused_ev;
    assign unused_ev   = stall_ev ^ bubble_ev;
    assign o_stall_cnt = 32'd0;
    assign o_flush_cnt = 32'd0;
`endif

    assign o_imem_raddr = pc_q;
    assign o_flush      = i_branch_taken;
    assign o_inst       = inst_q;
    assign o_pc         = idpc_q;
    assign o_nxt_pc     = nxt_q;
    assign o_vld        = vld_q;

endmodule

// File: tb/tb_fe.sv
// tb/tb_fe.sv - directed scoreboard bench for the fetch stage

module tb_fe;

    localparam logic [31:0] NOP = 32'h00000033;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_raddr;
    logic [31:0] imem_rdata;
    logic        hold, jal, jalr, br;
    logic [31:0] imm, rs1, tgt;
    logic [31:0] inst, pc, nxt_pc;
    logic        vld, flush;
    logic [31:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] nxt;
        logic [31:0] inst;
        logic        vld;
        logic [31:0] raddr;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ 32'hDEAD0000;
    endfunction

    assign imem_rdata = imem(imem_raddr);

    fe #(.RESET_ADDR(32'h00000000)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_raddr(imem_raddr), .i_imem_rdata(imem_rdata),
        .i_hold(hold), .i_jal(jal), .i_jalr(jalr),
        .i_immediate(imm), .i_jalr_rs1(rs1),
        .i_branch_taken(br), .i_branch_target(tgt),
        .o_inst(inst), .o_pc(pc), .o_nxt_pc(nxt_pc), .o_vld(vld),
        .o_flush(flush), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, push the expected IF/ID state, clock, pop and compare.
    task automatic step(input logic r, input logic h, input logic j, input logic jr,
                        input logic b, input logic [31:0] t, input logic [31:0] im,
                        input logic [31:0] s1,
                        input logic [31:0] e_pc, input logic [31:0] e_nxt,
                        input logic [31:0] e_inst, input logic e_vld,
                        input logic [31:0] e_raddr);
        exp_t e;
        exp_t got;
        logic [31:0] es, ef;
        rst = r; hold = h; jal = j; jalr = jr; br = b; tgt = t; imm = im; rs1 = s1;
        #1;
        chk("flush_comb", {31'd0, flush}, {31'd0, b});
        e.pc = e_pc; e.nxt = e_nxt; e.inst = e_inst; e.vld = e_vld; e.raddr = e_raddr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (r) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (h && !b) exp_stall++;
            if (b || (!h && (j || jr))) exp_flush++;
        end
        got = sb.pop_front();
        chk("pc",    pc,         got.pc);
        chk("nxt",   nxt_pc,     got.nxt);
        chk("inst",  inst,       got.inst);
        chk("vld",   {31'd0, vld}, {31'd0, got.vld});
        chk("raddr", imem_raddr, got.raddr);
`ifdef FE_PERF_CNT_EN
        es = exp_stall; ef = exp_flush;
`else
        es = 32'd0; ef = 32'd0;
`endif
        chk("stall_cnt", stall_cnt, es);
        chk("flush_cnt", flush_cnt, ef);
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; jal = 1'b0; jalr = 1'b0; br = 1'b0;
        tgt = 32'd0; imm = 32'd0; rs1 = 32'd0;
        @(posedge clk);
        #1;
        //   rst h  j  jr b  tgt           imm       rs1        pc            nxt           inst              vld  raddr
        // reset overrides branch, hold and jal; flush still follows branch
        step(1, 1, 1, 0, 1, 32'h200,      32'h40,   32'h0,     32'h0,        32'h0,        NOP,              0,   32'h0);
        step(1, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,     32'h0,        32'h0,        NOP,              0,   32'h0);
        // sequential fetch after reset release
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,     32'h0,        32'h4,        imem(32'h0),      1,   32'h4);
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,     32'h4,        32'h8,        imem(32'h4),      1,   32'h8);
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,     32'h8,        32'hC,        imem(32'h8),      1,   32'hC);
        // three held cycles at o_pc=8, jal ignored while held
        step(0, 1, 0, 0, 0, 32'h0,        32'h0,    32'h0,     32'h8,        32'hC,        imem(32'h8),      1,   32'hC);
        step(0, 1, 1, 0, 0, 32'h0,        32'h40,   32'h0,     32'h8,        32'hC,        imem(32'h8),      1,   32'hC);
        step(0, 1, 0, 0, 0, 32'h0,        32'h0,    32'h0,     32'h8,        32'hC,        imem(32'h8),      1,   32'hC);
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,     32'hC,        32'h10,       imem(32'hC),      1,   32'h10);
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,     32'h10,       32'h14,       imem(32'h10),     1,   32'h14);
        // jal from 0x10 by 0x20 -> one bubble then 0x30
        step(0, 0, 1, 0, 0, 32'h0,        32'h20,   32'h0,     32'h10,       32'h14,       NOP,              0,   32'h30);
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,     32'h30,       32'h34,       imem(32'h30),     1,   32'h34);
        // jalr 0x101+4 with bit 0 cleared -> 0x104
        step(0, 0, 0, 1, 0, 32'h0,        32'h4,    32'h101,   32'h30,       32'h34,       NOP,              0,   32'h104);
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,     32'h104,      32'h108,      imem(32'h104),    1,   32'h108);
        // jal and jalr together behave as jal
        step(0, 0, 1, 1, 0, 32'h0,        32'h8,    32'h500,   32'h104,      32'h108,      NOP,              0,   32'h10C);
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,     32'h10C,      32'h110,      imem(32'h10C),    1,   32'h110);
        // branch beats hold and jal
        step(0, 1, 1, 0, 1, 32'h200,      32'h40,   32'h0,     32'h10C,      32'h110,      NOP,              0,   32'h200);
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,     32'h200,      32'h204,      imem(32'h200),    1,   32'h204);
        // PC wrap at the top of the address space
        step(0, 0, 0, 0, 1, 32'hFFFFFFFC, 32'h0,    32'h0,     32'h200,      32'h204,      NOP,              0,   32'hFFFFFFFC);
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,     32'hFFFFFFFC, 32'h0,        imem(32'hFFFFFFFC), 1, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,     32'h0,        32'h4,        imem(32'h0),      1,   32'h4);
        step(0, 1, 0, 0, 0, 32'h0,        32'h0,    32'h0,     32'h0,        32'h4,        imem(32'h0),      1,   32'h4);
        // reset during hold with a pending jalr discards everything
        step(1, 1, 0, 1, 0, 32'h0,        32'h8,    32'h700,   32'h0,        32'h0,        NOP,              0,   32'h0);
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,     32'h0,        32'h4,        imem(32'h0),      1,   32'h4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
